// File: rtl/digit_pkg.sv
// Shared types and constants for the digit answer confirmation path.
package digit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_FIRE  = 2'd2,
      S_LOCK  = 2'd3
   } state_t;

   localparam logic [3:0] DIGIT_MAX     = 4'd9;
   localparam logic [3:0] DIGIT_NONE    = 4'hF;
   localparam logic [3:0] DIGIT_TIMEOUT = 4'hE;

   function automatic logic is_digit(input logic [3:0] d);
      return (d <= DIGIT_MAX);
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter stepped by frame ticks; stops at zero and flags it.
module frame_countdown #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_r;

   // Load has priority over tick; decrement stops at zero instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_value;
      end else if (tick && (count_r != '0)) begin
         count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == '0);

endmodule

// File: rtl/answer_confirm.sv
// Confirms a classifier digit after CONFIRM_COUNT matching predictions, then locks out.
// Optional no-answer timeout is compiled in with `define ANSWER_TIMEOUT_EN.
module answer_confirm
   import digit_pkg::*;
#(
   parameter int CONFIRM_COUNT  = 4,
   parameter int LOCKOUT_FRAMES = 60,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_tick,
   input  logic       i_pred_valid,
   input  logic [3:0] i_pred_digit,
   output logic [3:0] o_digit_answered,
   output logic       o_digit_identified,
   output logic [3:0] o_candidate,
   output logic       o_busy
);

   localparam logic [3:0] CONFIRM_W = 4'(CONFIRM_COUNT);
   localparam logic [7:0] LOCKOUT_W = 8'(LOCKOUT_FRAMES);

   state_t     state_r;
   state_t     state_s;
   logic [3:0] candidate_r;
   logic [3:0] candidate_s;
   logic [3:0] streak_r;
   logic [3:0] streak_s;
   logic [3:0] streak_inc_s;
   logic [3:0] answer_r;
   logic [3:0] answer_s;
   logic       identified_r;
   logic       busy_r;
   logic       confirm_s;
   logic       pred_ok_s;
   logic       pred_rej_s;

   logic       lock_load_s;
   logic       lock_tick_s;
   logic       lock_done_s;
   logic [7:0] lock_count_s;
   logic       lock_zero_s;
   logic       timeout_hit_s;

   assign pred_ok_s    = i_pred_valid & is_digit(i_pred_digit);
   assign pred_rej_s   = i_pred_valid & ~is_digit(i_pred_digit);
   assign streak_inc_s = (streak_r == 4'hF) ? streak_r : (streak_r + 4'd1);

   // Lockout counter is armed while firing and drained by frame ticks in S_LOCK.
   assign lock_load_s = (state_r == S_FIRE);
   assign lock_tick_s = i_frame_tick & (state_r == S_LOCK);
   assign lock_done_s = lock_tick_s & ((lock_count_s == 8'd1) | lock_zero_s);

   frame_countdown #(
      .WIDTH (8)
   ) u_lock (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (lock_load_s),
      .load_value (LOCKOUT_W),
      .tick       (lock_tick_s),
      .count      (lock_count_s),
      .zero       (lock_zero_s)
   );

`ifdef ANSWER_TIMEOUT_EN
   localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT_FRAMES);

   logic       tmo_armed_r;
   logic       tmo_run_s;
   logic       tmo_load_s;
   logic       tmo_tick_s;
   logic [9:0] tmo_count_s;
   logic       tmo_zero_s;

   // The first tick of a search window loads the remaining-frames count.
   assign tmo_run_s     = i_frame_tick & ((state_r == S_IDLE) | (state_r == S_COUNT));
   assign tmo_load_s    = tmo_run_s & ~tmo_armed_r;
   assign tmo_tick_s    = tmo_run_s & tmo_armed_r;
   assign timeout_hit_s = tmo_run_s & (tmo_armed_r ? ((tmo_count_s == 10'd1) | tmo_zero_s)
                                                   : (TIMEOUT_W == 10'd1));

   frame_countdown #(
      .WIDTH (10)
   ) u_timeout (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (tmo_load_s),
      .load_value (TIMEOUT_W - 10'd1),
      .tick       (tmo_tick_s),
      .count      (tmo_count_s),
      .zero       (tmo_zero_s)
   );

   // Window restarts after every answer (fire or lockout) and on reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tmo_armed_r <= 1'b0;
      end else if ((state_r == S_FIRE) || (state_r == S_LOCK)) begin
         tmo_armed_r <= 1'b0;
      end else if (tmo_load_s) begin
         tmo_armed_r <= 1'b1;
      end else begin
         tmo_armed_r <= tmo_armed_r;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state and next-register values; confirmation beats timeout.
   always_comb begin
      state_s     = state_r;
      candidate_s = candidate_r;
      streak_s    = streak_r;
      answer_s    = answer_r;
      confirm_s   = 1'b0;
      case (state_r)
         S_IDLE, S_COUNT: begin
            if (pred_ok_s) begin
               if ((state_r == S_COUNT) && (i_pred_digit == candidate_r)) begin
                  streak_s = streak_inc_s;
               end else begin
                  candidate_s = i_pred_digit;
                  streak_s    = 4'd1;
               end
               if (streak_s >= CONFIRM_W) begin
                  confirm_s = 1'b1;
               end else begin
                  state_s = S_COUNT;
               end
            end else if (pred_rej_s) begin
               streak_s    = 4'd0;
               candidate_s = DIGIT_NONE;
               state_s     = S_IDLE;
            end else begin
               state_s = state_r;
            end
            if (confirm_s) begin
               state_s  = S_FIRE;
               answer_s = candidate_s;
            end else if (timeout_hit_s) begin
               state_s  = S_FIRE;
               answer_s = DIGIT_TIMEOUT;
            end else begin
               answer_s = answer_r;
            end
         end
         S_FIRE: begin
            if (LOCKOUT_W == 8'd0) begin
               state_s     = S_IDLE;
               streak_s    = 4'd0;
               candidate_s = DIGIT_NONE;
            end else begin
               state_s = S_LOCK;
            end
         end
         S_LOCK: begin
            if (lock_done_s) begin
               state_s     = S_IDLE;
               streak_s    = 4'd0;
               candidate_s = DIGIT_NONE;
            end else begin
               state_s = S_LOCK;
            end
         end
         default: begin
            state_s     = S_IDLE;
            streak_s    = 4'd0;
            candidate_s = DIGIT_NONE;
         end
      endcase
   end

   // State and output registers; outputs reflect the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= S_IDLE;
         candidate_r  <= DIGIT_NONE;
         streak_r     <= 4'd0;
         answer_r     <= 4'd0;
         identified_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         candidate_r  <= candidate_s;
         streak_r     <= streak_s;
         answer_r     <= answer_s;
         identified_r <= (state_s == S_FIRE);
         busy_r       <= (state_s == S_FIRE) || (state_s == S_LOCK);
      end
   end

   assign o_digit_answered   = answer_r;
   assign o_digit_identified = identified_r;
   assign o_candidate        = candidate_r;
   assign o_busy             = busy_r;

endmodule

// File: doc/answer_confirm.md
ANSWER_CONFIRM -- requirements
Module: answer_confirm

Interface
REQ-001 SHALL have parameter CONFIRM_COUNT, default 4 (legal 1..15): matching consecutive predictions needed to confirm a digit.
REQ-002 SHALL have parameter LOCKOUT_FRAMES, default 60 (legal 0..255): frames ignored after a confirmation so the downstream scroll can finish.
REQ-003 SHALL have parameter TIMEOUT_FRAMES, default 600 (legal 1..1023): frames without a confirmation before a timeout answer is issued; used only under REQ-030.
REQ-004 Interface decision: one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 i_pred_valid  input  1  classifier prediction strobe, one cycle per prediction.
REQ-009 i_pred_digit  input  4  classifier digit; 0..9 valid, 10..15 reject.
REQ-010 o_digit_answered  output  4  last confirmed digit, held; feeds scroll i_digit_answered.
REQ-011 o_digit_identified  output  1  one-cycle confirmation pulse; feeds scroll i_digit_identified.
REQ-012 o_candidate  output  4  current candidate digit (debug).
REQ-013 o_busy  output  1  high in S_FIRE and S_LOCK.

Function
REQ-014 States: S_IDLE, S_COUNT, S_FIRE, S_LOCK; all outputs registered.
REQ-015 S_IDLE, i_pred_valid with digit 0..9: candidate=digit, streak=1, go S_COUNT (S_FIRE directly if CONFIRM_COUNT==1).
REQ-016 S_COUNT, valid prediction equal to candidate: streak+1; on reaching CONFIRM_COUNT go S_FIRE.
REQ-017 S_COUNT, valid prediction 0..9 differing from candidate: candidate=new digit, streak=1, stay S_COUNT.
REQ-018 S_IDLE/S_COUNT, valid prediction 10..15: streak=0, candidate=4'hF, go S_IDLE.
REQ-019 Cycles without i_pred_valid SHALL leave streak and candidate unchanged.
REQ-020 S_FIRE lasts exactly one cycle: o_digit_identified=1, o_digit_answered=candidate; next state S_LOCK with lock counter=LOCKOUT_FRAMES, or S_IDLE if LOCKOUT_FRAMES==0.
REQ-021 Latency: pulse asserted in the cycle after the edge sampling the CONFIRM_COUNT-th matching prediction.
REQ-022 S_LOCK: i_pred_valid ignored; each i_frame_tick decrements lock counter; tick bringing it to 0 moves to S_IDLE with streak=0, candidate=4'hF.
REQ-023 o_digit_answered SHALL change only in S_FIRE; o_digit_identified never high two consecutive cycles.
REQ-024 Streak counter SHALL saturate, never wrap; lock counter SHALL never underflow.

Reset
REQ-025 i_rst high at a clock edge: state S_IDLE, streak 0, lock and timeout counters 0.
REQ-026 Reset values: o_digit_answered=0, o_digit_identified=0, o_candidate=4'hF, o_busy=0.
REQ-027 Reset asserted in S_FIRE SHALL suppress the pulse that cycle; reset overrides all inputs.

Configuration
REQ-028 Macro ANSWER_TIMEOUT_EN controls the timeout feature.
REQ-029 Without it: no timeout counter, TIMEOUT_FRAMES unused, never emits 4'hE.
REQ-030 With it: frame ticks counted in S_IDLE/S_COUNT, cleared on entry to S_IDLE from S_LOCK and on reset; on reaching TIMEOUT_FRAMES go S_FIRE with o_digit_answered=4'hE.
REQ-031 With it: confirmation and timeout in the same cycle, confirmation wins.

Structure
REQ-032 Shared package digit_pkg SHALL hold state enum, DIGIT_MAX=9, DIGIT_NONE=4'hF, DIGIT_TIMEOUT=4'hE.
REQ-033 One sub-module frame_countdown (load, tick-enabled decrement, zero flag) SHALL serve lockout and timeout counters.

Verification
REQ-034 Reset, then 4 valid predictions of 7 -> one pulse, o_digit_answered=7, cycle after 4th; o_busy=1.
REQ-035 Predictions 3,3,5,5,5,5 -> single pulse with 5; no pulse for 3.
REQ-036 After confirm, predictions of 2 during 60 frame ticks -> no pulse; 4 more 2s after 60th tick -> pulse with 2.
REQ-037 Predictions 4,4,12,4,4 -> no pulse; two further 4s -> pulse with 4.
REQ-038 ANSWER_TIMEOUT_EN, TIMEOUT_FRAMES=3, no predictions, 3 ticks -> pulse with 4'hE; 4th match on 3rd tick -> candidate wins.
REQ-039 i_rst in S_FIRE cycle -> no pulse, o_digit_answered=0, state S_IDLE.
